// File: rtl/bcd_convert_scheduler.sv
// rtl/bcd_convert_scheduler.sv - shared shift-add-3 converter granted round-robin to sec/min/hr fields
module bcd_convert_scheduler #(
    parameter int W = 6
) (
    input  logic         clk_c,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] segundos,
    input  logic [W-1:0] minutos,
    input  logic [W-1:0] horas,
    output logic [3:0]   seg1,
    output logic [3:0]   seg2,
    output logic [3:0]   min1,
    output logic [3:0]   min2,
    output logic [3:0]   hora1,
    output logic [3:0]   hora2,
    output logic         busy,
    output logic         done
);
    localparam int SW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t         state, state_nx;
    logic [W-1:0]   in_v [0:2];
    logic [W-1:0]   cap [0:2];
    logic [2:0]     req;
    logic [1:0]     ptr, gnt, grant_sel, idx;
    logic           any_req, found;
    logic [W+7:0]   sr, sr_adj, sr_shift;
    logic [SW-1:0]  step;
    logic           load, shift, commit;

    function automatic logic [1:0] next3(input logic [1:0] c);
        return (c == 2'd2) ? 2'd0 : c + 2'd1;
    endfunction

    assign in_v[0] = segundos;
    assign in_v[1] = minutos;
    assign in_v[2] = horas;

    always_comb begin
        for (int c = 0; c < 3; c++) req[c] = (in_v[c] != cap[c]);
    end
    assign any_req = |req;

    // First requester in order ptr, ptr+1, ptr+2 (mod 3)
    always_comb begin
        grant_sel = ptr;
        found     = 1'b0;
        idx       = ptr;
        for (int k = 0; k < 3; k++) begin
            if (!found && req[idx]) begin
                grant_sel = idx;
                found     = 1'b1;
            end
            idx = next3(idx);
        end
    end

    always_comb begin
        sr_adj = sr;
        if (sr[W+3:W] >= 4'd5) sr_adj[W+3:W] = sr[W+3:W] + 4'd3;
        if (sr[W+7:W+4] >= 4'd5) sr_adj[W+7:W+4] = sr[W+7:W+4] + 4'd3;
        sr_shift = {sr_adj[W+6:0], 1'b0};
    end

    always_ff @(posedge clk_c or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        shift    = 1'b0;
        commit   = 1'b0;
        if (en) begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        load     = 1'b1;
                        state_nx = SHIFT;
                    end
                end
                SHIFT: begin
                    shift = 1'b1;
                    if (step == SW'(W - 1)) state_nx = COMMIT;
                end
                COMMIT: begin
                    commit   = 1'b1;
                    state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk_c or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 3; c++) cap[c] <= '0;
            sr    <= '0;
            step  <= '0;
            gnt   <= 2'd0;
            ptr   <= 2'd0;
            done  <= 1'b0;
            seg1  <= 4'd0;
            seg2  <= 4'd0;
            min1  <= 4'd0;
            min2  <= 4'd0;
            hora1 <= 4'd0;
            hora2 <= 4'd0;
        end else begin
            // done follows commit every clk_c, so it drops even while en=0
            done <= commit;
            if (load) begin
                cap[grant_sel] <= in_v[grant_sel];
                sr             <= {8'b0, in_v[grant_sel]};
                step           <= '0;
                gnt            <= grant_sel;
            end
            if (shift) begin
                sr   <= sr_shift;
                step <= step + SW'(1);
            end
            if (commit) begin
                case (gnt)
                    2'd0:    begin seg2  <= sr[W+7:W+4]; seg1  <= sr[W+3:W]; end
                    2'd1:    begin min2  <= sr[W+7:W+4]; min1  <= sr[W+3:W]; end
                    default: begin hora2 <= sr[W+7:W+4]; hora1 <= sr[W+3:W]; end
                endcase
                ptr <= next3(gnt);
            end
        end
    end
endmodule

// File: tb/tb_bcd_convert_scheduler.sv
// tb/tb_bcd_convert_scheduler.sv - directed self-checking bench for bcd_convert_scheduler
module tb_bcd_convert_scheduler;
    logic       clk_c = 1'b0;
    logic       rst   = 1'b1;
    logic       en    = 1'b1;
    logic [5:0] segundos = 6'd0, minutos = 6'd0, horas = 6'd0;
    logic [3:0] seg1, seg2, min1, min2, hora1, hora2;
    logic       busy, done;

    int checks = 0;
    int errors = 0;
    logic [23:0] exp_d = 24'h0;
    logic [23:0] digits;

    assign digits = {hora2, hora1, min2, min1, seg2, seg1};

    bcd_convert_scheduler #(.W(6)) dut (
        .clk_c(clk_c), .rst(rst), .en(en),
        .segundos(segundos), .minutos(minutos), .horas(horas),
        .seg1(seg1), .seg2(seg2), .min1(min1), .min2(min2),
        .hora1(hora1), .hora2(hora2), .busy(busy), .done(done)
    );

    always #5 clk_c = ~clk_c;

    task automatic tick();
        @(posedge clk_c);
        #1;
    endtask

    task automatic wait_done(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int busy_cnt;
        segundos = 6'd7; minutos = 6'd8; horas = 6'd9;
        rst = 1'b1;
        tick(); tick();
        checks++;
        if (digits !== 24'h0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state digits=%h busy=%b done=%b required 000000/0/0", digits, busy, done);
        end
        segundos = 6'd0; minutos = 6'd0; horas = 6'd0;
        tick();
        rst = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (busy !== 1'b0) busy_cnt++;
        end
        checks++;
        if (busy_cnt != 0) begin
            errors++;
            $display("FAIL reset_idle busy cycles=%0d required 0", busy_cnt);
        end
    endtask

    task automatic test_single(input logic [5:0] v, input logic [7:0] bcd);
        segundos = v;
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || digits !== exp_d) begin
            errors++;
            $display("FAIL single_pre_%0d done=%b busy=%b digits=%h required 0/1/%h", v, done, busy, digits, exp_d);
        end
        tick();
        exp_d[7:0] = bcd;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || digits !== exp_d) begin
            errors++;
            $display("FAIL single_commit_%0d done=%b busy=%b digits=%h required 1/0/%h", v, done, busy, digits, exp_d);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL single_done_pulse_%0d done=%b required 0", v, done);
        end
    endtask

    task automatic test_simultaneous();
        int n;
        segundos = 6'd0; minutos = 6'd0; horas = 6'd0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_d = 24'h0;
        segundos = 6'd59; minutos = 6'd59; horas = 6'd23;
        wait_done(12, n);
        checks++;
        if (n != 8 || digits !== 24'h000059) begin
            errors++;
            $display("FAIL simul_sec edge=%0d digits=%h required 8/000059", n, digits);
        end
        wait_done(12, n);
        checks++;
        if (n != 8 || digits !== 24'h005959) begin
            errors++;
            $display("FAIL simul_min edge=%0d digits=%h required 16/005959", n + 8, digits);
        end
        wait_done(12, n);
        checks++;
        if (n != 8 || digits !== 24'h235959) begin
            errors++;
            $display("FAIL simul_hr edge=%0d digits=%h required 24/235959", n + 16, digits);
        end
        exp_d = 24'h235959;
    endtask

    task automatic test_enable_gating();
        int  ne;
        bit  found, was;
        minutos = 6'd30;
        ne = 0;
        found = 1'b0;
        for (int k = 0; k < 64 && !found; k++) begin
            en  = (k % 4 == 0);
            was = en;
            tick();
            if (was) ne++;
            if (done === 1'b1) found = 1'b1;
        end
        en = 1'b0;
        exp_d[15:8] = 8'h30;
        checks++;
        if (!found || ne != 8 || digits !== exp_d) begin
            errors++;
            $display("FAIL enable_gating found=%0d enabled_edges=%0d digits=%h required 1/8/%h", found, ne, digits, exp_d);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL enable_done_drop done=%b busy=%b required 0/0", done, busy);
        end
        en = 1'b1;
    endtask

    task automatic test_mid_change();
        int n;
        segundos = 6'd10;
        for (int i = 0; i < 4; i++) tick();
        segundos = 6'd11;
        wait_done(10, n);
        exp_d[7:0] = 8'h10;
        checks++;
        if (n != 4 || digits !== exp_d) begin
            errors++;
            $display("FAIL mid_first edge=%0d digits=%h required 8/%h", n + 4, digits, exp_d);
        end
        wait_done(10, n);
        exp_d[7:0] = 8'h11;
        checks++;
        if (n != 8 || digits !== exp_d) begin
            errors++;
            $display("FAIL mid_reconvert edges=%0d digits=%h required 8/%h", n, digits, exp_d);
        end
    endtask

    task automatic test_reset_fairness();
        int got;
        segundos = 6'd33;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        #1;
        checks++;
        if (digits !== 24'h0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset digits=%h busy=%b done=%b required 000000/0/0", digits, busy, done);
        end
        segundos = 6'd5; minutos = 6'd12; horas = 6'd0;
        tick();
        rst = 1'b0;
        got = -1;
        for (int n = 1; n <= 24 && got < 0; n++) begin
            if (n % 8 == 4) segundos = (segundos == 6'd5) ? 6'd6 : 6'd5;
            tick();
            if ({min2, min1} === 8'h12) got = n;
        end
        checks++;
        if (got != 16 || digits[7:0] !== 8'h05) begin
            errors++;
            $display("FAIL fairness min_commit_edge=%0d sec=%h required 16/05", got, digits[7:0]);
        end
    endtask

    initial begin
        test_reset();
        test_single(6'd45, 8'h45);
        test_single(6'd63, 8'h63);
        test_single(6'd9, 8'h09);
        test_simultaneous();
        test_enable_gating();
        test_mid_change();
        test_reset_fairness();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
